// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit row writer: command bytes, wake nibbles,
// sequencer state encodings and small helpers.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_DDRAM_L1  = 8'h80;
   localparam logic [7:0] CMD_DDRAM_L2  = 8'hC0;

   localparam logic [3:0] NIB_WAKE = 4'h3;
   localparam logic [3:0] NIB_4BIT = 4'h2;

   typedef enum logic [2:0] {
      S_POWERUP,
      S_INIT,
      S_CFG,
      S_L1_ADDR,
      S_L1_DATA,
      S_L2_ADDR,
      S_L2_DATA,
      S_FRAME_END
   } lcd_state_t;

   // Progress of one transfer: issue first nibble, wait for it, wait for the low nibble, post-wait.
   typedef enum logic [1:0] {
      PH_ISSUE,
      PH_HI_WAIT,
      PH_LO_WAIT,
      PH_DELAY
   } xfer_phase_t;

   typedef struct packed {
      logic       rs;
      logic       nibble_only;
      logic [7:0] data;
   } xfer_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Character i of a row; the leftmost character sits in the top byte.
   function automatic logic [7:0] char_at(input logic [127:0] row, input logic [3:0] idx);
      return row[127 - 8 * int'(idx) -: 8];
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// One 4-bit LCD write: RS/D set up, E pulse, RS/D hold, then a one-cycle done pulse.
// start is only accepted while idle; RS/D keep their value until the next start.
module lcd_nibble_tx
   import lcd_pkg::*;
#(
   parameter int T_SETUP = 5,
   parameter int T_EPW   = 30,
   parameter int T_HOLD  = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       rs,
   input  logic [3:0] nibble,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [3:0] lcd_d,
   output logic       done
);

   localparam int CW = $clog2(max_int(max_int(T_SETUP, T_EPW), T_HOLD) + 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SETUP,
      TX_PULSE,
      TX_HOLD
   } tx_state_t;

   tx_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          e_nxt, rs_nxt, done_nxt;
   logic [3:0]    d_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= TX_IDLE;
         cnt    <= '0;
         lcd_e  <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_d  <= 4'h0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         lcd_e  <= e_nxt;
         lcd_rs <= rs_nxt;
         lcd_d  <= d_nxt;
         done   <= done_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      e_nxt     = lcd_e;
      rs_nxt    = lcd_rs;
      d_nxt     = lcd_d;
      done_nxt  = 1'b0;
      unique case (state)
         TX_IDLE: begin
            if (start) begin
               rs_nxt    = rs;
               d_nxt     = nibble;
               cnt_nxt   = CW'(T_SETUP - 1);
               state_nxt = TX_SETUP;
            end
         end
         TX_SETUP: begin
            if (cnt == '0) begin
               e_nxt     = 1'b1;
               cnt_nxt   = CW'(T_EPW - 1);
               state_nxt = TX_PULSE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         TX_PULSE: begin
            if (cnt == '0) begin
               e_nxt     = 1'b0;
               cnt_nxt   = CW'(T_HOLD - 1);
               state_nxt = TX_HOLD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         TX_HOLD: begin
            if (cnt == '0) begin
               done_nxt  = 1'b1;
               state_nxt = TX_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/lcd_row_writer.sv
// HD44780 16x2 driver: power-on init over the 4-bit bus, then endless refresh of both
// lines from a per-frame snapshot of row_a/row_b.
module lcd_row_writer
   import lcd_pkg::*;
#(
   parameter int T_POWERUP = 2_000_000,
   parameter int T_INIT1   = 500_000,
   parameter int T_INIT2   = 15_000,
   parameter int T_EXEC    = 5_000,
   parameter int T_CLEAR   = 200_000,
   parameter int T_SETUP   = 5,
   parameter int T_EPW     = 30,
   parameter int T_HOLD    = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [127:0] row_a,
   input  logic [127:0] row_b,
   output logic         LCD_E,
   output logic         LCD_RS,
   output logic         LCD_RW,
   output logic [3:0]   LCD_D,
   output logic         ready,
   output logic         frame_done
);

   localparam int T_MAX = max_int(max_int(max_int(T_POWERUP, T_INIT1),
                                          max_int(T_INIT2, T_EXEC)), T_CLEAR);
   localparam int TW    = $clog2(T_MAX + 1);

   lcd_state_t    state, state_nxt;
   xfer_phase_t   phase, phase_nxt;
   logic [1:0]    step, step_nxt;
   logic [3:0]    char_idx, char_idx_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          ready_nxt;
   logic [127:0]  snap_a, snap_b;

   xfer_t         cur;
   logic [TW-1:0] cur_wait;
   logic          tx_start, tx_done;
   logic [3:0]    tx_nibble;

   lcd_nibble_tx #(
      .T_SETUP (T_SETUP),
      .T_EPW   (T_EPW),
      .T_HOLD  (T_HOLD)
   ) u_tx (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (tx_start),
      .rs      (cur.rs),
      .nibble  (tx_nibble),
      .lcd_e   (LCD_E),
      .lcd_rs  (LCD_RS),
      .lcd_d   (LCD_D),
      .done    (tx_done)
   );

   assign LCD_RW     = 1'b0;
   assign frame_done = (state == S_FRAME_END);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_POWERUP;
         phase    <= PH_ISSUE;
         step     <= 2'd0;
         char_idx <= 4'd0;
         timer    <= TW'(T_POWERUP - 1);
         ready    <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         step     <= step_nxt;
         char_idx <= char_idx_nxt;
         timer    <= timer_nxt;
         ready    <= ready_nxt;
      end
   end

   // NOTE: the snapshot is pure data, always loaded before it is read, so it needs no reset.
   always_ff @(posedge clk) begin
      if (reset_n && state_nxt == S_L1_ADDR && state != S_L1_ADDR) begin
         snap_a <= row_a;
         snap_b <= row_b;
      end
   end

   // What the current state/step sends, and how long to wait after it (stored as wait-1).
   always_comb begin
      cur      = '0;
      cur_wait = TW'(T_EXEC - 1);
      unique case (state)
         S_INIT: begin
            cur.nibble_only = 1'b1;
            cur.data        = {4'h0, (step == 2'd3) ? NIB_4BIT : NIB_WAKE};
            cur_wait        = (step == 2'd0) ? TW'(T_INIT1 - 1) : TW'(T_INIT2 - 1);
         end
         S_CFG: begin
            unique case (step)
               2'd0:    cur.data = CMD_FUNC_4BIT;
               2'd1:    cur.data = CMD_DISP_ON;
               2'd2:    cur.data = CMD_ENTRY_INC;
               default: begin
                  cur.data = CMD_CLEAR;
                  cur_wait = TW'(T_CLEAR - 1);
               end
            endcase
         end
         S_L1_ADDR: cur.data = CMD_DDRAM_L1;
         S_L1_DATA: begin
            cur.rs   = 1'b1;
            cur.data = char_at(snap_a, char_idx);
         end
         S_L2_ADDR: cur.data = CMD_DDRAM_L2;
         S_L2_DATA: begin
            cur.rs   = 1'b1;
            cur.data = char_at(snap_b, char_idx);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      step_nxt     = step;
      char_idx_nxt = char_idx;
      timer_nxt    = timer;
      ready_nxt    = ready;
      tx_start     = 1'b0;
      tx_nibble    = cur.data[3:0];

      if (state == S_POWERUP) begin
         if (timer == '0) begin
            state_nxt = S_INIT;
            phase_nxt = PH_ISSUE;
         end else begin
            timer_nxt = timer - 1'b1;
         end
      end else if (state == S_FRAME_END) begin
         state_nxt = S_L1_ADDR;
         phase_nxt = PH_ISSUE;
      end else begin
         unique case (phase)
            PH_ISSUE: begin
               tx_start = 1'b1;
               if (cur.nibble_only) begin
                  phase_nxt = PH_LO_WAIT;
               end else begin
                  tx_nibble = cur.data[7:4];
                  phase_nxt = PH_HI_WAIT;
               end
            end
            PH_HI_WAIT: begin
               // The low nibble starts in the same cycle the high nibble reports done.
               if (tx_done) begin
                  tx_start  = 1'b1;
                  phase_nxt = PH_LO_WAIT;
               end
            end
            PH_LO_WAIT: begin
               if (tx_done) begin
                  timer_nxt = cur_wait;
                  phase_nxt = PH_DELAY;
               end
            end
            PH_DELAY: begin
               if (timer != '0) begin
                  timer_nxt = timer - 1'b1;
               end else begin
                  phase_nxt = PH_ISSUE;
                  unique case (state)
                     S_INIT: begin
                        step_nxt = step + 2'd1;
                        if (step == 2'd3) state_nxt = S_CFG;
                     end
                     S_CFG: begin
                        step_nxt = step + 2'd1;
                        if (step == 2'd3) begin
                           state_nxt = S_L1_ADDR;
                           ready_nxt = 1'b1;
                        end
                     end
                     S_L1_ADDR: state_nxt = S_L1_DATA;
                     S_L1_DATA: begin
                        char_idx_nxt = char_idx + 4'd1;
                        if (char_idx == 4'd15) state_nxt = S_L2_ADDR;
                     end
                     S_L2_ADDR: state_nxt = S_L2_DATA;
                     S_L2_DATA: begin
                        char_idx_nxt = char_idx + 4'd1;
                        if (char_idx == 4'd15) state_nxt = S_FRAME_END;
                     end
                     default: state_nxt = S_POWERUP;
                  endcase
               end
            end
            default: phase_nxt = PH_ISSUE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_row_writer.sv
// Self-checking bench for lcd_row_writer: nibble scoreboard sampled at E falls plus
// bus-timing, ready, frame_done and reset checks.
`timescale 1ns/1ps
module tb_lcd_row_writer;

   localparam int T_POWERUP = 100;
   localparam int T_INIT1   = 50;
   localparam int T_INIT2   = 10;
   localparam int T_EXEC    = 8;
   localparam int T_CLEAR   = 40;
   localparam int T_SETUP   = 2;
   localparam int T_EPW     = 4;
   localparam int T_HOLD    = 2;

   localparam int INIT_NIBS   = 12;
   localparam int FRAME_NIBS  = 68;
   localparam int WAIT_BUDGET = 4000;

   localparam logic [127:0] FIBO_A  = "Fibo #01 is 0001";
   localparam logic [127:0] FIBO_B  = "Fibo #02 is 0001";
   localparam logic [127:0] PRESS_A = "Press BTN3 to   ";

   typedef struct {
      logic       rs;
      logic [3:0] nib;
      int         gap;
   } exp_nib_t;

   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
   } frame_vec_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [127:0] row_a, row_b;
   logic         lcd_e, lcd_rs, lcd_rw, ready, frame_done;
   logic [3:0]   lcd_d;

   int n_checks = 0;
   int n_errors = 0;

   exp_nib_t   sb[$];
   exp_nib_t   init_tbl[INIT_NIBS];
   frame_vec_t frame_tbl[3];

   int nib_seen   = 0;
   int frames     = 0;
   int rw_bad     = 0;
   int e_in_reset = 0;

   lcd_row_writer #(
      .T_POWERUP (T_POWERUP),
      .T_INIT1   (T_INIT1),
      .T_INIT2   (T_INIT2),
      .T_EXEC    (T_EXEC),
      .T_CLEAR   (T_CLEAR),
      .T_SETUP   (T_SETUP),
      .T_EPW     (T_EPW),
      .T_HOLD    (T_HOLD)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .row_a      (row_a),
      .row_b      (row_b),
      .LCD_E      (lcd_e),
      .LCD_RS     (lcd_rs),
      .LCD_RW     (lcd_rw),
      .LCD_D      (lcd_d),
      .ready      (ready),
      .frame_done (frame_done)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d frames, want 3", frames);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input bit ok, input longint act, input longint req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic push_byte(input logic rs, input logic [7:0] b, input int gap);
      sb.push_back('{rs, b[7:4], 0});
      sb.push_back('{rs, b[3:0], gap});
   endtask

   task automatic push_init();
      for (int i = 0; i < INIT_NIBS; i++) sb.push_back(init_tbl[i]);
   endtask

   task automatic push_frame(input logic [127:0] a, input logic [127:0] b);
      push_byte(1'b0, 8'h80, T_EXEC);
      for (int i = 0; i < 16; i++) push_byte(1'b1, a[127 - 8 * i -: 8], T_EXEC);
      push_byte(1'b0, 8'hC0, T_EXEC);
      for (int i = 0; i < 16; i++) push_byte(1'b1, b[127 - 8 * i -: 8], T_EXEC);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_e"},          lcd_e === 1'b0,      lcd_e,      0);
      check({tag, "_rs"},         lcd_rs === 1'b0,     lcd_rs,     0);
      check({tag, "_d"},          lcd_d === 4'h0,      lcd_d,      0);
      check({tag, "_ready"},      ready === 1'b0,      ready,      0);
      check({tag, "_frame_done"}, frame_done === 1'b0, frame_done, 0);
   endtask

   task automatic wait_nibs(input int target);
      int i = 0;
      while (nib_seen < target && i < WAIT_BUDGET) begin
         @(negedge clk);
         i++;
      end
      check($sformatf("wait_nibs_%0d", target), nib_seen >= target, nib_seen, target);
      #1;
   endtask

   task automatic wait_frames(input int target);
      int i = 0;
      while (frames < target && i < WAIT_BUDGET) begin
         @(negedge clk);
         i++;
      end
      check($sformatf("wait_frames_%0d", target), frames >= target, frames, target);
      #1;
   endtask

   // Bus monitor: samples on the falling clock edge, away from the DUT's active edge.
   initial begin
      logic     prev_e, prev_ready, prev_fd, have_fall;
      logic [4:0] prev_rsd, rsd;
      int       cyc, since_fall, high_cnt, stable_cnt, need_gap, fr_run;
      exp_nib_t exp_item;
      prev_e = 0; prev_ready = 0; prev_fd = 0; have_fall = 0; prev_rsd = '0;
      cyc = 0; since_fall = 0; high_cnt = 0; stable_cnt = 0; need_gap = 0; fr_run = 0;
      forever begin
         @(negedge clk);
         if (lcd_rw !== 1'b0) rw_bad++;
         if (reset_n !== 1'b1) begin
            if (lcd_e !== 1'b0) e_in_reset++;
            nib_seen = 0; fr_run = 0; cyc = 0; since_fall = 0; high_cnt = 0;
            stable_cnt = 0; need_gap = 0; have_fall = 0;
            prev_e = 0; prev_ready = 0; prev_fd = 0; prev_rsd = '0;
         end else begin
            cyc++;
            since_fall++;
            rsd = {lcd_rs, lcd_d};
            if (rsd !== prev_rsd) begin
               check("rsd_stable_around_e",
                     !lcd_e && !prev_e && (!have_fall || since_fall >= T_HOLD),
                     since_fall, T_HOLD);
               stable_cnt = 0;
            end else begin
               stable_cnt++;
            end
            if (lcd_e && !prev_e) begin
               check("setup", stable_cnt >= T_SETUP, stable_cnt, T_SETUP);
               if (nib_seen == 0)
                  check("powerup_wait", cyc >= T_POWERUP + T_SETUP, cyc, T_POWERUP + T_SETUP);
               else
                  check("post_gap", since_fall >= need_gap, since_fall, need_gap);
               check("ready_at_rise", ready === (nib_seen >= INIT_NIBS), ready,
                     longint'(nib_seen >= INIT_NIBS));
               high_cnt = 0;
            end
            if (lcd_e) high_cnt++;
            if (!lcd_e && prev_e) begin
               check("e_width", high_cnt == T_EPW, high_cnt, T_EPW);
               if (sb.size() == 0) begin
                  check("unexpected_nibble", 1'b0, rsd, 0);
                  need_gap = 0;
               end else begin
                  exp_item = sb.pop_front();
                  check($sformatf("nibble_%0d", nib_seen), rsd === {exp_item.rs, exp_item.nib},
                        rsd, {exp_item.rs, exp_item.nib});
                  need_gap = exp_item.gap;
               end
               nib_seen++;
               have_fall  = 1;
               since_fall = 0;
            end
            if (ready !== prev_ready) begin
               check("ready_rise_after_clear",
                     ready === 1'b1 && nib_seen == INIT_NIBS && since_fall >= T_CLEAR,
                     since_fall, T_CLEAR);
            end
            if (frame_done === 1'b1) begin
               check("frame_done_width", !prev_fd, prev_fd, 0);
               if (!prev_fd) begin
                  fr_run++;
                  frames++;
                  check("frame_done_pos", nib_seen == INIT_NIBS + FRAME_NIBS * fr_run,
                        nib_seen, INIT_NIBS + FRAME_NIBS * fr_run);
               end
            end
            prev_e     = lcd_e;
            prev_ready = ready;
            prev_fd    = frame_done;
            prev_rsd   = rsd;
         end
      end
   end

   initial begin
      int frames_before;
      reset_n = 1'b0;
      row_a   = FIBO_A;
      row_b   = FIBO_B;

      init_tbl[0]  = '{1'b0, 4'h3, T_INIT1};
      init_tbl[1]  = '{1'b0, 4'h3, T_INIT2};
      init_tbl[2]  = '{1'b0, 4'h3, T_INIT2};
      init_tbl[3]  = '{1'b0, 4'h2, T_INIT2};
      init_tbl[4]  = '{1'b0, 4'h2, 0};
      init_tbl[5]  = '{1'b0, 4'h8, T_EXEC};
      init_tbl[6]  = '{1'b0, 4'h0, 0};
      init_tbl[7]  = '{1'b0, 4'hC, T_EXEC};
      init_tbl[8]  = '{1'b0, 4'h0, 0};
      init_tbl[9]  = '{1'b0, 4'h6, T_EXEC};
      init_tbl[10] = '{1'b0, 4'h0, 0};
      init_tbl[11] = '{1'b0, 4'h1, T_CLEAR};

      // Frame 2 is sent from the old snapshot even though row_a changes mid-frame.
      frame_tbl[0] = '{FIBO_A,  FIBO_B};
      frame_tbl[1] = '{FIBO_A,  FIBO_B};
      frame_tbl[2] = '{PRESS_A, FIBO_B};

      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      push_init();
      for (int f = 0; f < 3; f++) push_frame(frame_tbl[f].a, frame_tbl[f].b);
      reset_n = 1'b1;

      // Line-1 char 5 of frame 2 is in flight once char 4's low nibble has been seen.
      wait_nibs(INIT_NIBS + FRAME_NIBS + 2 + 10);
      row_a = PRESS_A;

      wait_frames(2);

      // Frame 3: reset for one cycle while line-1 char 3 is being sent.
      wait_nibs(INIT_NIBS + 2 * FRAME_NIBS + 2 + 6);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      sb.delete();
      @(negedge clk);
      #1;
      check_reset_outputs("mid_reset");
      reset_n = 1'b1;
      push_init();
      push_frame(row_a, row_b);

      frames_before = frames;
      wait_frames(frames_before + 1);
      repeat (5) @(negedge clk);

      check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
      check("lcd_rw_always_low", rw_bad == 0, rw_bad, 0);
      check("no_e_during_reset", e_in_reset == 0, e_in_reset, 0);
      check("frames_total", frames == 3, frames, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
